// File: rtl/dii_worm_arbiter_if.sv
// DII flit bundle: N input ports, one arbitrated output link, grant and orphan status.
// The master modport drives flits in and takes the output; the slave is the arbiter.
interface dii_worm_arbiter_if #(
  parameter int N  = 3,
  parameter int DW = 16
);
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_first;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_first;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            err_orphan;

  modport master (
    output in_data, in_first, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_first, out_last, out_valid, grant, err_orphan
  );

  modport slave (
    input  in_data, in_first, in_last, in_valid, out_ready,
    output in_ready, out_data, out_first, out_last, out_valid, grant, err_orphan
  );
endinterface

// File: rtl/dii_worm_arbiter.sv
// Worm-level arbiter: ring port 0 has priority, bounded by RING_MAX consecutive worms
// while locals wait; local ports are served round-robin; a granted worm holds the link.
module dii_worm_arbiter #(
  parameter int N        = 3,
  parameter int DW       = 16,
  parameter int RING_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  dii_worm_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int SW = $clog2(RING_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;

  logic [N-1:0]  cand;
  logic [N-1:0]  orphan;
  logic          local_any;
  logic          ring_win;
  logic          local_found;
  logic [PW-1:0] local_pick;
  logic [DW-1:0] in_flit [N];

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
    if (s >= SW'(RING_MAX)) return SW'(RING_MAX);
    return s + SW'(1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign in_flit[g] = bus.in_data[g*DW +: DW];
  end

  // Arbitration: ring priority with starvation bound, then round-robin over 1..N-1.
  always_comb begin : p_pick
    int idx;
    idx         = 0;
    cand        = bus.in_valid & bus.in_first;
    orphan      = bus.in_valid & ~bus.in_first;
    local_any   = |cand[N-1:1];
    ring_win    = cand[0] && ((streak_q < SW'(RING_MAX)) || !local_any);
    local_found = 1'b0;
    local_pick  = '0;
    for (int off = 0; off < N-1; off++) begin
      idx = int'(rr_q) + off;
      if (idx > N-1) idx = idx - (N-1);
      if (!local_found && cand[idx[PW-1:0]]) begin
        local_found = 1'b1;
        local_pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    streak_d      = streak_q;
    err_d         = 1'b0;
    bus.out_data  = '0;
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_valid = 1'b0;
    bus.in_ready  = '0;
    bus.grant     = '0;
    case (state_q)
      IDLE: begin
        // Non-first flits seen while idle are consumed and discarded.
        bus.in_ready = orphan;
        err_d        = |orphan;
        if (ring_win) begin
          state_d  = LOCKED;
          owner_d  = '0;
          streak_d = sat_inc(streak_q);
        end else if (local_found) begin
          state_d  = LOCKED;
          owner_d  = local_pick;
          streak_d = '0;
          rr_d     = (local_pick == PW'(N-1)) ? PW'(1) : local_pick + PW'(1);
        end
      end
      LOCKED: begin
        bus.out_data           = in_flit[owner_q];
        bus.out_first          = bus.in_first[owner_q];
        bus.out_last           = bus.in_last[owner_q];
        bus.out_valid          = bus.in_valid[owner_q];
        bus.in_ready[owner_q]  = bus.out_ready;
        bus.grant[owner_q]     = 1'b1;
        if (bus.in_valid[owner_q] && bus.out_ready && bus.in_last[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= PW'(1);
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  assign bus.err_orphan = err_q;
endmodule

// File: tb/tb_dii_worm_arbiter.sv
// Directed bench for dii_worm_arbiter: per-port flit queues feed the DUT, the output
// is logged on each transfer, and each scenario task compares against hand-derived values.
module tb_dii_worm_arbiter;
  localparam int N        = 3;
  localparam int DW       = 16;
  localparam int RING_MAX = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_req;
  logic rdy;

  int tests = 0;
  int fails = 0;

  flit_t q0[$];
  flit_t q1[$];
  flit_t q2[$];

  logic          cur_valid, cur_first, cur_last, cur_err;
  logic [DW-1:0] cur_data;
  logic [N-1:0]  cur_grant, cur_ready;

  int            log_port[$];
  logic [DW-1:0] log_data[$];
  logic          log_first[$];

  dii_worm_arbiter_if #(.N(N), .DW(DW)) bus ();

  dii_worm_arbiter #(.N(N), .DW(DW), .RING_MAX(RING_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int qsize(input int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic flit_t qhead(input int p);
    case (p)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int p);
    case (p)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic push(input int p, input logic [DW-1:0] d, input logic f, input logic l);
    flit_t x;
    x.d = d; x.f = f; x.l = l;
    case (p)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic push_worm(input int p, input logic [DW-1:0] base, input int len);
    for (int k = 0; k < len; k++)
      push(p, base + DW'(k), (k == 0), (k == len-1));
  endtask

  function automatic int gidx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic clear_queues();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic clear_log();
    log_port.delete(); log_data.delete(); log_first.delete();
  endtask

  // One clock: drive at negedge, sample 1ns later, retire accepted flits.
  task automatic step();
    flit_t h;
    @(negedge clk);
    rst = rst_req;
    bus.out_ready = rdy;
    for (int p = 0; p < N; p++) begin
      if (qsize(p) > 0) begin
        h = qhead(p);
        bus.in_valid[p] = 1'b1;
        bus.in_first[p] = h.f;
        bus.in_last[p]  = h.l;
        bus.in_data[p*DW +: DW] = h.d;
      end else begin
        bus.in_valid[p] = 1'b0;
        bus.in_first[p] = 1'b0;
        bus.in_last[p]  = 1'b0;
        bus.in_data[p*DW +: DW] = '0;
      end
    end
    #1;
    cur_valid = bus.out_valid;
    cur_first = bus.out_first;
    cur_last  = bus.out_last;
    cur_data  = bus.out_data;
    cur_grant = bus.grant;
    cur_ready = bus.in_ready;
    cur_err   = bus.err_orphan;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      log_port.push_back(gidx(bus.grant));
      log_data.push_back(bus.out_data);
      log_first.push_back(bus.out_first);
    end
    for (int p = 0; p < N; p++)
      if (bus.in_ready[p] === 1'b1) qpop(p);
  endtask

  task automatic apply_reset();
    rst_req = 1'b1;
    rdy     = 1'b1;
    clear_queues();
    step();
    step();
    rst_req = 1'b0;
    clear_log();
  endtask

  task automatic run_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int first_port(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < log_port.size(); i++) begin
      if (log_first[i]) begin
        if (cnt == n) return log_port[i];
        cnt++;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_req = 1'b1;
    rdy     = 1'b1;
    clear_queues();
    step();
    step();
    rst_req = 1'b0;
    push(1, 16'h0011, 1'b0, 1'b0);
    push(1, 16'h0022, 1'b0, 1'b0);
    step();
    rst_req = 1'b1;
    step();
    step();
    tests++; if (cur_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", cur_valid); end
    tests++; if (cur_grant !== 3'b000) begin fails++; $display("FAIL reset_grant: got %b want 000", cur_grant); end
    tests++; if (cur_ready !== 3'b000) begin fails++; $display("FAIL reset_in_ready: got %b want 000", cur_ready); end
    tests++; if (cur_err !== 1'b0) begin fails++; $display("FAIL reset_err_orphan: got %b want 0", cur_err); end
    rst_req = 1'b0;
    clear_log();
  endtask

  task automatic test_single_ring();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 16'h00A1; exp_d[1] = 16'h00A2; exp_d[2] = 16'h00A3;
    apply_reset();
    push(0, 16'h00A1, 1'b1, 1'b0);
    push(0, 16'h00A2, 1'b0, 1'b0);
    push(0, 16'h00A3, 1'b0, 1'b1);
    step();
    tests++; if (cur_valid !== 1'b0 || cur_grant !== 3'b000) begin fails++; $display("FAIL ring_idle_cycle: valid=%b grant=%b want 0/000", cur_valid, cur_grant); end
    tests++; if (cur_ready !== 3'b000) begin fails++; $display("FAIL ring_idle_ready: got %b want 000", cur_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (cur_valid !== 1'b1 || cur_grant !== 3'b001) begin fails++; $display("FAIL ring_flit%0d_grant: valid=%b grant=%b want 1/001", k, cur_valid, cur_grant); end
      tests++; if (cur_data !== exp_d[k]) begin fails++; $display("FAIL ring_flit%0d_data: got %h want %h", k, cur_data, exp_d[k]); end
      tests++; if (cur_first !== (k == 0) || cur_last !== (k == 2)) begin fails++; $display("FAIL ring_flit%0d_flags: first=%b last=%b", k, cur_first, cur_last); end
    end
    step();
    tests++; if (cur_valid !== 1'b0 || cur_grant !== 3'b000) begin fails++; $display("FAIL ring_back_idle: valid=%b grant=%b want 0/000", cur_valid, cur_grant); end
  endtask

  task automatic test_starvation();
    int exp_p [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit ok;
    apply_reset();
    for (int w = 0; w < 8; w++) push_worm(0, DW'(16'h0A00 + 16*w), 2);
    push_worm(1, 16'h1B00, 2);
    push_worm(1, 16'h1B10, 2);
    run_drain(80, ok);
    tests++; if (!ok) begin fails++; $display("FAIL starve_drain: queues left %0d/%0d want 0/0", q0.size(), q1.size()); end
    for (int n = 0; n < 10; n++) begin
      tests++; if (first_port(n) !== exp_p[n]) begin fails++; $display("FAIL starve_order%0d: got port %0d want %0d", n, first_port(n), exp_p[n]); end
    end
  endtask

  task automatic test_local_rr();
    int exp_p [4] = '{1, 2, 1, 2};
    bit ok;
    apply_reset();
    push_worm(1, 16'h1100, 2);
    push_worm(1, 16'h1110, 2);
    push_worm(2, 16'h2200, 2);
    push_worm(2, 16'h2210, 2);
    run_drain(40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rr_drain: queues left %0d/%0d want 0/0", q1.size(), q2.size()); end
    for (int n = 0; n < 4; n++) begin
      tests++; if (first_port(n) !== exp_p[n]) begin fails++; $display("FAIL rr_order%0d: got port %0d want %0d", n, first_port(n), exp_p[n]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [6];
    bit ok;
    exp_d = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4, 16'h00D1, 16'h00D2};
    apply_reset();
    push(2, 16'h00C1, 1'b1, 1'b0);
    push(2, 16'h00C2, 1'b0, 1'b0);
    push(2, 16'h00C3, 1'b0, 1'b0);
    push(2, 16'h00C4, 1'b0, 1'b1);
    step();
    step();
    tests++; if (cur_grant !== 3'b100 || cur_data !== 16'h00C1) begin fails++; $display("FAIL bp_first: grant=%b data=%h want 100/00c1", cur_grant, cur_data); end
    rdy = 1'b0;
    push(1, 16'h00D1, 1'b1, 1'b0);
    push(1, 16'h00D2, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      tests++; if (cur_valid !== 1'b1 || cur_data !== 16'h00C2) begin fails++; $display("FAIL bp_hold%0d: valid=%b data=%h want 1/00c2", c, cur_valid, cur_data); end
      tests++; if (cur_ready !== 3'b000) begin fails++; $display("FAIL bp_ready%0d: got %b want 000", c, cur_ready); end
    end
    rdy = 1'b1;
    run_drain(40, ok);
    tests++; if (!ok || log_data.size() != 6) begin fails++; $display("FAIL bp_count: got %0d flits want 6", log_data.size()); end
    for (int i = 0; i < 6 && i < log_data.size(); i++) begin
      tests++; if (log_data[i] !== exp_d[i]) begin fails++; $display("FAIL bp_data%0d: got %h want %h", i, log_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_orphan();
    apply_reset();
    push(1, 16'h0055, 1'b0, 1'b0);
    step();
    tests++; if (cur_ready !== 3'b010) begin fails++; $display("FAIL orphan_ready: got %b want 010", cur_ready); end
    tests++; if (cur_valid !== 1'b0 || cur_err !== 1'b0) begin fails++; $display("FAIL orphan_cycle0: valid=%b err=%b want 0/0", cur_valid, cur_err); end
    step();
    tests++; if (cur_err !== 1'b1) begin fails++; $display("FAIL orphan_pulse: got %b want 1", cur_err); end
    tests++; if (cur_ready !== 3'b000 || cur_valid !== 1'b0) begin fails++; $display("FAIL orphan_after: ready=%b valid=%b want 000/0", cur_ready, cur_valid); end
    step();
    tests++; if (cur_err !== 1'b0) begin fails++; $display("FAIL orphan_pulse_end: got %b want 0", cur_err); end
    tests++; if (log_data.size() != 0) begin fails++; $display("FAIL orphan_leak: got %0d output flits want 0", log_data.size()); end
  endtask

  task automatic test_reset_mid_worm();
    int exp_p [6] = '{0, 0, 0, 0, 1, 2};
    bit ok;
    apply_reset();
    push_worm(1, 16'h00E1, 4);
    step();
    step();
    tests++; if (cur_data !== 16'h00E1 || cur_grant !== 3'b010) begin fails++; $display("FAIL mid_e1: data=%h grant=%b want 00e1/010", cur_data, cur_grant); end
    rst_req = 1'b1;
    step();
    tests++; if (cur_data !== 16'h00E2) begin fails++; $display("FAIL mid_e2: got %h want 00e2", cur_data); end
    rst_req = 1'b0;
    clear_queues();
    step();
    tests++; if (cur_valid !== 1'b0 || cur_grant !== 3'b000) begin fails++; $display("FAIL mid_after_reset: valid=%b grant=%b want 0/000", cur_valid, cur_grant); end
    clear_log();
    for (int w = 0; w < 4; w++) push_worm(0, DW'(16'h0B00 + w), 1);
    push_worm(1, 16'h0B11, 1);
    push_worm(2, 16'h0B21, 1);
    run_drain(40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_drain: queues left %0d/%0d/%0d want 0", q0.size(), q1.size(), q2.size()); end
    for (int n = 0; n < 6; n++) begin
      tests++; if (first_port(n) !== exp_p[n]) begin fails++; $display("FAIL mid_order%0d: got port %0d want %0d", n, first_port(n), exp_p[n]); end
    end
  endtask

  initial begin
    rst_req = 1'b1;
    rdy     = 1'b1;
    bus.in_valid  = '0;
    bus.in_first  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single_ring();
    test_starvation();
    test_local_rr();
    test_backpressure();
    test_orphan();
    test_reset_mid_worm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
